// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus: pipeline result, M-unit handshake,
// register-file write port and hazard-side pending mask.
interface wb_write_arbiter_if;
    logic        PIPE_WRITE;
    logic [4:0]  PIPE_ADDR;
    logic [31:0] PIPE_DATA;
    logic        MD_VALID;
    logic [4:0]  MD_ADDR;
    logic [31:0] MD_DATA;
    logic        MD_READY;
    logic        WB_WRITE;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic [31:0] PENDING;
    logic        PIPE_STALL;

    modport master (
        output PIPE_WRITE, PIPE_ADDR, PIPE_DATA,
        output MD_VALID, MD_ADDR, MD_DATA,
        input  MD_READY,
        input  WB_WRITE, WB_ADDR, WB_DATA,
        input  PENDING, PIPE_STALL
    );

    modport slave (
        input  PIPE_WRITE, PIPE_ADDR, PIPE_DATA,
        input  MD_VALID, MD_ADDR, MD_DATA,
        output MD_READY,
        output WB_WRITE, WB_ADDR, WB_DATA,
        output PENDING, PIPE_STALL
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: pipeline results win, M-unit results queue in a FIFO.
// Optional starvation guard enabled by defining WB_ARB_STARVE_EN.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    wb_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [31:0]      r_pending;
    logic             r_wb_write;
    logic [4:0]       r_wb_addr;
    logic [31:0]      r_wb_data;

    logic             w_full;
    logic             w_empty;
    logic             w_md_ready;
    logic             w_raw_act;
    logic             w_pipe_act;
    logic             w_push;
    logic             w_pop;
    logic             w_head_live;
    logic             w_push_live;
    logic [DEPTH-1:0] w_live_nxt;
    logic [31:0]      w_pend_nxt;
    logic [4:0]       w_slot_addr;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_md_ready = !RESET && !w_full;
    assign w_raw_act  = bus.PIPE_WRITE && (bus.PIPE_ADDR != 5'd0);

`ifdef WB_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          r_stall;

    // A stall cycle masks the pipeline so the head can drain.
    assign w_pipe_act = w_raw_act && !r_stall;

    // Count full-and-blocked cycles; fire a one-cycle stall at the limit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else if (r_stall) begin
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else if (w_full && w_raw_act) begin
            if (r_starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                r_starve_cnt <= '0;
                r_stall      <= 1'b1;
            end else begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign bus.PIPE_STALL = r_stall;
`else
    assign w_pipe_act     = w_raw_act;
    assign bus.PIPE_STALL = 1'b0;
`endif

    assign w_push      = bus.MD_VALID && w_md_ready;
    assign w_pop       = !w_pipe_act && !w_empty;
    assign w_head_live = r_live[r_rptr];

    // A same-cycle pipeline write to the same register is younger.
    assign w_push_live = (bus.MD_ADDR != 5'd0) &&
                         !(w_pipe_act &&
                           (bus.PIPE_ADDR == bus.MD_ADDR));

    // Next live bits and the pending mask they imply.
    always_comb begin
        w_live_nxt  = r_live;
        w_pend_nxt  = '0;
        w_slot_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_act && (r_addr[i] == bus.PIPE_ADDR))
                w_live_nxt[i] = 1'b0;
        end
        if (w_pop)
            w_live_nxt[r_rptr] = 1'b0;
        if (w_push)
            w_live_nxt[r_wptr] = w_push_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == AW'(i)))
                w_slot_addr = bus.MD_ADDR;
            else
                w_slot_addr = r_addr[i];
            if (w_live_nxt[i])
                w_pend_nxt = w_pend_nxt | (32'd1 << w_slot_addr);
        end
    end

    // FIFO payload storage; validity is tracked by count and live bits.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_addr[r_wptr] <= bus.MD_ADDR;
            r_data[r_wptr] <= bus.MD_DATA;
        end
    end

    // FIFO pointers, occupancy, live bits and pending mask.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_live    <= '0;
            r_pending <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_live    <= w_live_nxt;
            r_pending <= w_pend_nxt;
        end
    end

    // Registered register-file write; address/data hold when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wb_write <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_pipe_act) begin
            r_wb_write <= 1'b1;
            r_wb_addr  <= bus.PIPE_ADDR;
            r_wb_data  <= bus.PIPE_DATA;
        end else if (w_pop && w_head_live) begin
            r_wb_write <= 1'b1;
            r_wb_addr  <= r_addr[r_rptr];
            r_wb_data  <= r_data[r_rptr];
        end else begin
            r_wb_write <= 1'b0;
        end
    end

    assign bus.MD_READY = w_md_ready;
    assign bus.WB_WRITE = r_wb_write;
    assign bus.WB_ADDR  = r_wb_addr;
    assign bus.WB_DATA  = r_wb_data;
    assign bus.PENDING  = r_pending;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: queue-level reference model,
// expected writes queued by the driver and consumed by a monitor.
module tb_wb_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ent_t mq[$];
    wr_t  eq[$];
    bit   m_rst   = 1'b1;
    bit   m_stall = 1'b0;
    int   m_cnt   = 0;

    wb_write_arbiter_if bus();

    wb_write_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i])
            if (mq[i].live) p |= 32'd1 << mq[i].a;
        return p;
    endfunction

    // One cycle: check state, drive inputs, advance the model one edge.
    task automatic step(input bit r, input bit pw, input logic [4:0] pa,
                        input logic [31:0] pd, input bit mv,
                        input logic [4:0] ma, input logic [31:0] md);
        bit rdy;
        bit raw;
        bit act;
        bit full;
        ent_t e;
        wr_t  w;
        @(negedge clk);
        rdy = !m_rst && (mq.size() < DEPTH);
        chk("md_ready", {31'd0, bus.MD_READY}, {31'd0, rdy});
        chk("pending", bus.PENDING, model_pending());
        chk("pipe_stall", {31'd0, bus.PIPE_STALL}, {31'd0, m_stall});
        rst            = r;
        bus.PIPE_WRITE = pw;
        bus.PIPE_ADDR  = pa;
        bus.PIPE_DATA  = pd;
        bus.MD_VALID   = mv;
        bus.MD_ADDR    = ma;
        bus.MD_DATA    = md;
        m_rst          = r;
        if (r) begin
            mq.delete();
            m_stall = 1'b0;
            m_cnt   = 0;
        end else begin
            rdy  = mq.size() < DEPTH;
            full = !rdy;
            raw  = pw && (pa != 5'd0);
            act  = raw && !m_stall;
`ifdef WB_ARB_STARVE_EN
            if (m_stall) begin
                m_stall = 1'b0;
                m_cnt   = 0;
            end else if (full && raw) begin
                m_cnt++;
                if (m_cnt == STARVE_LIMIT) begin
                    m_stall = 1'b1;
                    m_cnt   = 0;
                end
            end else begin
                m_cnt = 0;
            end
`endif
            if (act) begin
                foreach (mq[i])
                    if (mq[i].a == pa) mq[i].live = 1'b0;
                w.due = cyc + 1;
                w.a   = pa;
                w.d   = pd;
                eq.push_back(w);
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    w.due = cyc + 1;
                    w.a   = e.a;
                    w.d   = e.d;
                    eq.push_back(w);
                end
            end
            if (mv && rdy) begin
                e.a    = ma;
                e.d    = md;
                e.live = (ma != 5'd0) && !(act && ma == pa);
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: every write must match the scoreboard head, on time.
    initial begin
        logic [4:0]  last_a;
        logic [31:0] last_d;
        bit          rs;
        wr_t         w;
        last_a = '0;
        last_d = '0;
        forever begin
            @(posedge clk);
            rs = rst;
            @(negedge clk);
            if (rs) begin
                chk("rst_wb_write", {31'd0, bus.WB_WRITE}, 32'd0);
                chk("rst_wb_addr", {27'd0, bus.WB_ADDR}, 32'd0);
                chk("rst_wb_data", bus.WB_DATA, 32'd0);
                last_a = '0;
                last_d = '0;
            end else if (bus.WB_WRITE) begin
                if (eq.size() == 0) begin
                    chk("unexpected_write", {27'd0, bus.WB_ADDR}, 32'hFFFF_FFFF);
                end else begin
                    w = eq.pop_front();
                    chk("wb_due", cyc, w.due);
                    chk("wb_addr", {27'd0, bus.WB_ADDR}, {27'd0, w.a});
                    chk("wb_data", bus.WB_DATA, w.d);
                end
                last_a = bus.WB_ADDR;
                last_d = bus.WB_DATA;
            end else begin
                chk("hold_addr", {27'd0, bus.WB_ADDR}, {27'd0, last_a});
                chk("hold_data", bus.WB_DATA, last_d);
                if (eq.size() > 0 && eq[0].due == cyc) begin
                    w = eq.pop_front();
                    chk("missing_write", 32'd0, {27'd0, w.a});
                end
            end
        end
    end

    initial begin
        int pwp;
        int mvp;
        bus.PIPE_WRITE = 1'b0;
        bus.PIPE_ADDR  = '0;
        bus.PIPE_DATA  = '0;
        bus.MD_VALID   = 1'b0;
        bus.MD_ADDR    = '0;
        bus.MD_DATA    = '0;

        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(3);

        step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        step(0, 1, 5'd0, 32'h1111_1111, 0, 5'd0, 32'd0);
        idle(2);

        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234_5678);
        idle(3);

        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(20 + i), 32'h100 + i, 1,
                 5'(10 + i), 32'h200 + i);
        step(0, 1, 5'd30, 32'h300, 0, 5'd0, 32'd0);
        idle(6);

        step(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h9999);
        step(0, 1, 5'd9, 32'hAAAA, 0, 5'd0, 32'd0);
        idle(3);
        step(0, 1, 5'd3, 32'h3333, 1, 5'd3, 32'hBAD3);
        idle(3);

        step(0, 0, 5'd0, 32'd0, 1, 5'd1, 32'h1);
        step(0, 1, 5'd2, 32'h2, 1, 5'd4, 32'h4);
        step(0, 1, 5'd2, 32'h2, 1, 5'd6, 32'h6);
        step(1, 1, 5'd2, 32'h2, 1, 5'd8, 32'h8);
        idle(4);

        for (int i = 0; i < 60; i++)
            step(0, 1, 5'd17, 32'h1700, 1, 5'($urandom_range(1, 31)),
                 $urandom);
        idle(8);

        for (int blk = 0; blk < 12; blk++) begin
            pwp = $urandom_range(10, 95);
            mvp = $urandom_range(10, 95);
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < pwp,
                     5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 99) < mvp,
                     5'($urandom_range(0, 7)), $urandom);
        end
        idle(10);

        chk("scoreboard_empty", eq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
